// File: rtl/fifo_rd_arbiter_if.sv
// FIFO read-side and consumer-side signals of the round-robin read arbiter.
// master: arbiter side; slave: FIFO/consumer environment side.
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    cons_ready;
  logic [CNT_WIDTH-1:0]  cfg_burst_len;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_REQ-1:0]    out_valid;
  logic                  burst_done;

  modport master (
    input  fifo_empty, fifo_rd_data, req, cons_ready, cfg_burst_len,
    output fifo_rd_en, grant, out_data, out_valid, burst_done
  );

  modport slave (
    output fifo_empty, fifo_rd_data, req, cons_ready, cfg_burst_len,
    input  fifo_rd_en, grant, out_data, out_valid, burst_done
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
// Pop is combinational from grant/ready/empty; popped words are registered out.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input logic                rd_clk,
  input logic                rd_rst,
  fifo_rd_arbiter_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      gidx;
  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  pick_found;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  limit;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  burst_done_q;
  logic                  pop;
  logic                  release_g;

  // First requester after the last-served index, wrapping NUM_REQ-1 -> 0
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    release_g = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !bus.fifo_empty) state_nxt = XFER;
      end
      XFER: begin
        pop = bus.req[gidx] & bus.cons_ready[gidx] & ~bus.fifo_empty;
        // An empty FIFO only stalls; the grant ends on a dropped request or a full burst
        if (!bus.req[gidx] || (pop && (count + CNT_ONE) == limit)) begin
          release_g = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state        <= IDLE;
      grant_q      <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      burst_done_q <= 1'b0;
      count        <= '0;
      limit        <= '0;
      gidx         <= '0;
      last         <= IDX_W'(NUM_REQ - 1);
    end else begin
      state        <= state_nxt;
      out_valid_q  <= '0;
      burst_done_q <= 1'b0;
      if (state == IDLE && state_nxt == XFER) begin
        grant_q <= NUM_REQ'(1) << pick_idx;
        gidx    <= pick_idx;
        limit   <= (bus.cfg_burst_len == '0) ? CNT_ONE : bus.cfg_burst_len;
        count   <= '0;
      end
      if (pop) begin
        out_data_q  <= bus.fifo_rd_data;
        out_valid_q <= grant_q;
        count       <= count + CNT_ONE;
      end
      if (release_g) begin
        grant_q      <= '0;
        last         <= gidx;
        burst_done_q <= 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.grant      = grant_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.burst_done = burst_done_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: FIFO model, scoreboard of expected words and
// grants, and a negedge monitor that pops and compares whatever the DUT presents.
module tb_fifo_rd_arbiter;
  typedef struct {
    logic [3:0] dst;
    logic [7:0] dat;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   bd_cnt = 0;
  bit   gap_chk = 0;

  logic [7:0] fq[$];
  exp_t       exp_q[$];
  logic [3:0] exp_g[$];

  fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic expect_word(input logic [3:0] dst, input logic [7:0] d);
    exp_t e;
    e.dst = dst;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input logic [3:0] g, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (bus.grant == g) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail(name);
  endtask

  task automatic wait_sb(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail(name);
  endtask

  // FIFO model: pops on the edge it saw fifo_rd_en, flag/data refreshed just after the edge
  initial begin
    logic       popd;
    logic [7:0] junk;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    forever begin
      @(posedge clk);
      popd = bus.fifo_rd_en;
      #1;
      if (popd) begin
        if (fq.size() == 0) fail("fifo_underflow");
        else junk = fq.pop_front();
      end
      bus.fifo_empty = (fq.size() == 0);
      if (fq.size() != 0) bus.fifo_rd_data = fq[0];
    end
  end

  // Monitor
  initial begin
    logic [3:0] prev_g;
    int         gap;
    bit         gap_valid;
    exp_t       e;
    prev_g    = '0;
    gap       = 0;
    gap_valid = 0;
    forever begin
      @(negedge clk);
      if (!gap_chk) gap_valid = 0;
      if (bus.out_valid != '0) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          e = exp_q.pop_front();
          check("word_dst", 32'(bus.out_valid), 32'(e.dst));
          check("word_dat", 32'(bus.out_data), 32'(e.dat));
        end
      end
      if (bus.burst_done) bd_cnt++;
      if (bus.grant != '0 && prev_g == '0) begin
        if (exp_g.size() == 0) fail("unexpected_grant");
        else check("grant_order", 32'(bus.grant), 32'(exp_g.pop_front()));
        if (gap_chk && gap_valid) check("idle_gap", gap, 1);
      end
      if (bus.grant != '0) begin
        gap       = 0;
        gap_valid = gap_chk;
      end else begin
        gap++;
      end
      prev_g = bus.grant;
    end
  end

  initial begin
    int bd0;
    rst               = 1'b1;
    bus.req           = '0;
    bus.cons_ready    = '0;
    bus.cfg_burst_len = 4'd1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_burst_done", 32'(bus.burst_done), 0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-burst: 3 of 8 words delivered, then reset kills the 4th pop
    for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
    exp_g.push_back(4'b0001);
    for (int i = 0; i < 3; i++) expect_word(4'b0001, 8'h10 + 8'(i));
    bus.cfg_burst_len = 4'd8;
    bus.cons_ready    = 4'b1111;
    bus.req           = 4'b0001;
    wait_sb("t1_three_words");
    rst = 1'b1;
    #1;
    check("t1_rst_grant", 32'(bus.grant), 0);
    check("t1_rst_out_valid", 32'(bus.out_valid), 0);
    check("t1_rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("t1_rst_out_data", 32'(bus.out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin over the 5 words left behind, one word per grant
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0100);
    exp_g.push_back(4'b1000);
    exp_g.push_back(4'b0001);
    expect_word(4'b0001, 8'h13);
    expect_word(4'b0010, 8'h14);
    expect_word(4'b0100, 8'h15);
    expect_word(4'b1000, 8'h16);
    expect_word(4'b0001, 8'h17);
    bus.cfg_burst_len = 4'd1;
    bus.req           = 4'b1111;
    gap_chk           = 1;
    wait_sb("t3_round_robin");
    repeat (2) @(negedge clk);
    check("t3_grants_left", exp_g.size(), 0);
    gap_chk = 0;
    bus.req = '0;
    @(negedge clk);

    // Single requester, burst 2 over A,B then C on a fresh grant
    bd0 = bd_cnt;
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    fq.push_back(8'hC3);
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0001);
    expect_word(4'b0001, 8'hA1);
    expect_word(4'b0001, 8'hB2);
    expect_word(4'b0001, 8'hC3);
    bus.cfg_burst_len = 4'd2;
    bus.req           = 4'b0001;
    gap_chk           = 1;
    wait_sb("t2_words");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("t2_hold_grant", 32'(bus.grant), 32'h1);
      check("t2_hold_rd_en", 32'(bus.fifo_rd_en), 0);
    end
    check("t2_out_data_held", 32'(bus.out_data), 32'hC3);
    check("t2_out_valid_idle", 32'(bus.out_valid), 0);
    bus.req = '0;
    wait_grant(4'b0000, "t2_release");
    check("t2_burst_done_cnt", bd_cnt - bd0, 2);
    gap_chk = 0;
    @(negedge clk);

    // Backpressure: ready toggles on consumer 1, cfg change after grant is ignored
    bd0 = bd_cnt;
    for (int i = 0; i < 4; i++) begin
      fq.push_back(8'h40 + 8'(i));
      expect_word(4'b0010, 8'h40 + 8'(i));
    end
    exp_g.push_back(4'b0010);
    bus.cfg_burst_len = 4'd4;
    bus.cons_ready    = 4'b1101;
    bus.req           = 4'b0010;
    wait_grant(4'b0010, "t4_grant");
    bus.cfg_burst_len = 4'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.cons_ready = (i % 2 == 0) ? 4'b1111 : 4'b1101;
      #1;
      check("t4_rd_en", 32'(bus.fifo_rd_en), (i % 2 == 0) ? 1 : 0);
    end
    wait_sb("t4_words");
    check("t4_burst_done_cnt", bd_cnt - bd0, 1);
    bus.req = '0;
    @(negedge clk);

    // Empty stall: 1 word, wait, refill 3; non-granted req changes ignored
    bd0 = bd_cnt;
    bus.cfg_burst_len = 4'd4;
    bus.cons_ready    = 4'b1111;
    fq.push_back(8'h50);
    expect_word(4'b0100, 8'h50);
    exp_g.push_back(4'b0100);
    bus.req = 4'b0100;
    wait_sb("t5_first_word");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req = 4'b0111;
      #1;
      check("t5_stall_grant", 32'(bus.grant), 32'h4);
      check("t5_stall_rd_en", 32'(bus.fifo_rd_en), 0);
    end
    for (int i = 1; i < 4; i++) begin
      fq.push_back(8'h50 + 8'(i));
      expect_word(4'b0100, 8'h50 + 8'(i));
    end
    wait_sb("t5_refill_words");
    wait_grant(4'b0000, "t5_release");
    check("t5_burst_done_cnt", bd_cnt - bd0, 1);
    bus.req = '0;
    @(negedge clk);

    // Early release after 2 of 5, req drops while ready is high
    bd0 = bd_cnt;
    for (int i = 0; i < 5; i++) fq.push_back(8'h60 + 8'(i));
    expect_word(4'b1000, 8'h60);
    expect_word(4'b1000, 8'h61);
    exp_g.push_back(4'b1000);
    bus.cfg_burst_len = 4'd5;
    bus.cons_ready    = 4'b0111;
    bus.req           = 4'b1000;
    wait_grant(4'b1000, "t6_grant");
    @(negedge clk);
    bus.cons_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    bus.req = '0;
    #1;
    check("t6_drop_rd_en", 32'(bus.fifo_rd_en), 0);
    wait_grant(4'b0000, "t6_release");
    check("t6_burst_done_cnt", bd_cnt - bd0, 1);
    wait_sb("t6_two_words");

    // Zero burst length: one word per grant, pointer resumes after consumer 3
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0100);
    expect_word(4'b0001, 8'h62);
    expect_word(4'b0010, 8'h63);
    expect_word(4'b0100, 8'h64);
    bus.cfg_burst_len = 4'd0;
    bus.req           = 4'b1111;
    gap_chk           = 1;
    wait_sb("t6_zero_len_words");
    repeat (4) @(negedge clk);
    gap_chk = 0;
    bus.req = '0;
    repeat (3) @(negedge clk);
    #2;
    check("end_words_left", exp_q.size(), 0);
    check("end_grants_left", exp_g.size(), 0);
    check("end_fifo_left", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
